// File: rtl/xor_train_sequencer.sv
// +--------------------------------------------------------------------------+
// | xor_train_sequencer: steps the XOR pattern set through a perceptron      |
// | datapath for a programmable number of epochs.                Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module xor_train_sequencer #(
  parameter int LAT     = 40,
  parameter int EPOCH_W = 16
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  input  logic               iABORT,
  input  logic [EPOCH_W-1:0] iEPOCHS,
  output logic [31:0]        oX0,
  output logic [31:0]        oX1,
  output logic [31:0]        oTEACH,
  output logic               oPAT_VALID,
  output logic               oLOAD_W,
  output logic [1:0]         oPAT_IDX,
  output logic [EPOCH_W-1:0] oEPOCH_CNT,
  output logic               oBUSY,
  output logic               oDONE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [15:0] LAT_M1 = 16'(LAT - 1);

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [15:0]        wait_q, wait_d;
  logic [EPOCH_W-1:0] epochs_q, epochs_d;
  logic [EPOCH_W-1:0] epoch_cnt_q, epoch_cnt_d;
  logic               x0_q, x0_d;
  logic               x1_q, x1_d;
  logic               teach_q, teach_d;
  logic               pat_valid;
  logic               load_w;
  logic               done;
  // One extra bit so a captured count of all-ones never wraps the compare.
  logic [EPOCH_W:0]   epoch_next;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    epochs_d    = epochs_q;
    epoch_cnt_d = epoch_cnt_q;
    pat_valid   = 1'b0;
    load_w      = 1'b0;
    done        = 1'b0;
    epoch_next  = {1'b0, epoch_cnt_q} + {{EPOCH_W{1'b0}}, 1'b1};

    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          epochs_d    = iEPOCHS;
          epoch_cnt_d = '0;
          idx_d       = 2'd0;
          state_d     = (iEPOCHS != '0) ? S_ISSUE : S_FINISH;
        end
      end
      S_ISSUE: begin
        pat_valid = 1'b1;
        wait_d    = LAT_M1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q != 16'd0) begin
          wait_d = wait_q - 16'd1;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        load_w = 1'b1;
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_ISSUE;
        end else begin
          epoch_cnt_d = epoch_next[EPOCH_W-1:0];
          if (epoch_next < {1'b0, epochs_q}) begin
            idx_d   = 2'd0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything and kills the strobes in the same cycle.
    if (iABORT && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      idx_d       = 2'd0;
      wait_d      = 16'd0;
      epoch_cnt_d = epoch_cnt_q;
      load_w      = 1'b0;
      done        = 1'b0;
    end

    x0_d    = idx_d[1];
    x1_d    = idx_d[0];
    teach_d = idx_d[1] ^ idx_d[0];
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      wait_q      <= 16'd0;
      epochs_q    <= '0;
      epoch_cnt_q <= '0;
      x0_q        <= 1'b0;
      x1_q        <= 1'b0;
      teach_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      epochs_q    <= epochs_d;
      epoch_cnt_q <= epoch_cnt_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      teach_q     <= teach_d;
    end
  end

  assign oX0        = {31'd0, x0_q};
  assign oX1        = {31'd0, x1_q};
  assign oTEACH     = {31'd0, teach_q};
  assign oPAT_VALID = pat_valid;
  assign oLOAD_W    = load_w;
  assign oPAT_IDX   = idx_q;
  assign oEPOCH_CNT = epoch_cnt_q;
  assign oBUSY      = (state_q != S_IDLE);
  assign oDONE      = done;

endmodule

`default_nettype wire

// File: tb/tb_xor_train_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_xor_train_sequencer: directed bench, one instance at LAT=40 and one   |
// | at LAT=1.                                                    Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_xor_train_sequencer;

  logic        clk;
  logic        rst;
  logic        start   [2];
  logic        abort   [2];
  logic [15:0] epochs  [2];
  logic [31:0] x0      [2];
  logic [31:0] x1      [2];
  logic [31:0] teach   [2];
  logic        pv      [2];
  logic        ld      [2];
  logic [1:0]  pidx    [2];
  logic [15:0] ecnt    [2];
  logic        busy    [2];
  logic        dn      [2];

  int n_checks = 0;
  int n_fail   = 0;

  int         load_q [$];
  int         pv_q   [$];
  int         done_q [$];
  logic [2:0] pat_q  [$];
  int         wide_bad;
  int         end_cyc;

  logic [2:0] exp_pat [4];

  xor_train_sequencer #(.LAT(40), .EPOCH_W(16)) u_dut_a (
    .iCLK(clk), .iRST(rst), .iSTART(start[0]), .iABORT(abort[0]), .iEPOCHS(epochs[0]),
    .oX0(x0[0]), .oX1(x1[0]), .oTEACH(teach[0]), .oPAT_VALID(pv[0]), .oLOAD_W(ld[0]),
    .oPAT_IDX(pidx[0]), .oEPOCH_CNT(ecnt[0]), .oBUSY(busy[0]), .oDONE(dn[0])
  );

  xor_train_sequencer #(.LAT(1), .EPOCH_W(16)) u_dut_b (
    .iCLK(clk), .iRST(rst), .iSTART(start[1]), .iABORT(abort[1]), .iEPOCHS(epochs[1]),
    .oX0(x0[1]), .oX1(x1[1]), .oTEACH(teach[1]), .oPAT_VALID(pv[1]), .oLOAD_W(ld[1]),
    .oPAT_IDX(pidx[1]), .oEPOCH_CNT(ecnt[1]), .oBUSY(busy[1]), .oDONE(dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts instance s from a negedge and logs events; cycle 1 is the cycle
  // after the start edge. Optional abort / restart pulses at given cycles.
  task automatic run_seq(input int s, input logic [15:0] e, input int max_cyc,
                         input int abort_cyc, input int restart_cyc);
    epochs[s] = e;
    start[s]  = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    load_q.delete(); pv_q.delete(); done_q.delete(); pat_q.delete();
    wide_bad = 0;
    end_cyc  = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      if (i == abort_cyc) begin abort[s] = 1'b1; #1; end
      if (i == restart_cyc) begin start[s] = 1'b1; epochs[s] = 16'd5; #1; end
      if (pv[s]) begin
        pv_q.push_back(i);
        pat_q.push_back({x0[s][0], x1[s][0], teach[s][0]});
      end
      if ((x0[s][31:1] != 0) || (x1[s][31:1] != 0) || (teach[s][31:1] != 0)) wide_bad++;
      if (ld[s]) load_q.push_back(i);
      if (dn[s]) done_q.push_back(i);
      if (!busy[s]) begin
        end_cyc = i;
        break;
      end
      @(negedge clk);
      abort[s] = 1'b0;
      start[s] = 1'b0;
    end
    if (end_cyc == 0) check("run_timeout", 1, 0);
  endtask

  initial begin
    int lcount;
    exp_pat[0] = 3'b000;
    exp_pat[1] = 3'b011;
    exp_pat[2] = 3'b101;
    exp_pat[3] = 3'b110;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; abort[s] = 1'b0; epochs[s] = 16'd0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy",  busy[0], 0);
    check("rst_cnt",   ecnt[0], 0);
    check("rst_x0",    x0[1],   0);
    check("rst_done",  dn[1],   0);
    rst = 1'b0;
    @(negedge clk);

    // Single epoch at LAT=40.
    run_seq(0, 16'd1, 400, 0, 0);
    check("s1_pv_n",   pv_q.size(),   4);
    check("s1_ld_n",   load_q.size(), 4);
    for (int n = 0; n < pv_q.size() && n < 4; n++) check("s1_pv_cyc", pv_q[n], 1 + n * 42);
    for (int n = 0; n < load_q.size() && n < 4; n++) check("s1_ld_cyc", load_q[n], (n + 1) * 42);
    for (int n = 0; n < pat_q.size() && n < 4; n++) check("s1_pat", pat_q[n], exp_pat[n]);
    check("s1_done_n", done_q.size(), 1);
    if (done_q.size() > 0) check("s1_done_cyc", done_q[0], 169);
    check("s1_end",    end_cyc,  170);
    check("s1_cnt",    ecnt[0],  1);
    check("s1_wide",   wide_bad, 0);

    // Three epochs at LAT=1.
    run_seq(1, 16'd3, 100, 0, 0);
    check("m3_ld_n", load_q.size(), 12);
    for (int n = 0; n < load_q.size(); n++) check("m3_ld_cyc", load_q[n], 3 * (n + 1));
    check("m3_pv_n", pat_q.size(), 12);
    for (int n = 0; n < pat_q.size(); n++) check("m3_pat", pat_q[n], exp_pat[n % 4]);
    if (done_q.size() > 0) check("m3_done_cyc", done_q[0], 37);
    else check("m3_done_n", 0, 1);
    check("m3_cnt",  ecnt[1],  3);
    check("m3_wide", wide_bad, 0);

    // Zero epochs: immediate done, counter cleared.
    run_seq(1, 16'd0, 20, 0, 0);
    check("z_pv_n",  pv_q.size(),   0);
    check("z_ld_n",  load_q.size(), 0);
    if (done_q.size() > 0) check("z_done_cyc", done_q[0], 1);
    else check("z_done_n", 0, 1);
    check("z_end",   end_cyc, 2);
    check("z_cnt",   ecnt[1], 0);

    // Abort in the COMMIT of pattern 2 during the second epoch.
    run_seq(1, 16'd3, 100, 21, 0);
    check("ab_ld_n",   load_q.size(), 6);
    if (load_q.size() > 0) check("ab_ld_last", load_q[load_q.size()-1], 18);
    check("ab_done_n", done_q.size(), 0);
    check("ab_end",    end_cyc, 22);
    check("ab_cnt",    ecnt[1], 1);
    check("ab_x0",     x0[1],   0);
    check("ab_idx",    pidx[1], 0);
    lcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ld[1] || dn[1] || busy[1]) lcount++;
    end
    check("ab_quiet", lcount, 0);

    // Start pulse mid-run must be ignored.
    run_seq(1, 16'd2, 100, 0, 5);
    check("sb_ld_n", load_q.size(), 8);
    if (done_q.size() > 0) check("sb_done_cyc", done_q[0], 25);
    else check("sb_done_n", 0, 1);
    check("sb_cnt",  ecnt[1], 2);
    epochs[1] = 16'd0;

    // Asynchronous reset in the WAIT of pattern 3.
    epochs[0] = 16'd2;
    start[0]  = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (129) @(negedge clk);
    check("rr_pre_busy",  busy[0],  1);
    check("rr_pre_x0",    x0[0],    1);
    check("rr_pre_x1",    x1[0],    1);
    check("rr_pre_teach", teach[0], 0);
    #2 rst = 1'b1;
    #1;
    check("rr_x0",   x0[0],   0);
    check("rr_x1",   x1[0],   0);
    check("rr_idx",  pidx[0], 0);
    check("rr_busy", busy[0], 0);
    check("rr_cnt",  ecnt[0], 0);
    check("rr_ld",   ld[0],   0);
    @(negedge clk);
    rst = 1'b0;
    lcount = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ld[0] || pv[0] || dn[0] || busy[0]) lcount++;
    end
    check("rr_quiet", lcount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/xor_train_sequencer.md
Name: xor_train_sequencer

Overview:
- Controller that sequences perceptron XOR training through the hidden/output layer datapath.
- Each epoch presents the 4 XOR patterns in a fixed order and drives input values and the teach value.
- After each pattern it waits the fixed datapath pipeline latency, then pulses a commit strobe so the weight registers latch the updated weights.
- Runs a programmable number of epochs, then signals done. Sits between the host/top-level control and the layer datapath.

Parameters:
- LAT, 40, datapath latency in cycles from pattern presentation to valid updated weights; legal range 1..65535.
- EPOCH_W, 16, width of the epoch count and epoch counter.

Ports:
- iCLK  input  1  clock; all state updates on rising edge.
- iRST  input  1  asynchronous, active-high reset.
- iSTART  input  1  start request; sampled only in IDLE.
- iABORT  input  1  abort the run; honoured in every non-IDLE state.
- iEPOCHS  input  EPOCH_W  number of epochs to run; captured on an accepted start.
- oX0  output  32  integer input x0 (0 or 1) to the datapath.
- oX1  output  32  integer input x1 (0 or 1) to the datapath.
- oTEACH  output  32  integer teach value (x0 XOR x1) to the datapath.
- oPAT_VALID  output  1  high for one cycle when a new pattern is presented.
- oLOAD_W  output  1  one-cycle weight commit strobe.
- oPAT_IDX  output  2  current pattern index.
- oEPOCH_CNT  output  EPOCH_W  number of completed epochs.
- oBUSY  output  1  high in every state except IDLE.
- oDONE  output  1  one-cycle pulse when the run completes.

Behaviour:
- Reset (async, iRST=1): state=IDLE; every output = 0; internal wait counter and captured epoch count cleared.
- Pattern table, indexed by idx as (x0,x1 -> teach):
  - 0: (0,0 -> 0)
  - 1: (0,1 -> 1)
  - 2: (1,0 -> 1)
  - 3: (1,1 -> 0)
  - oX0, oX1 and oTEACH are registered and driven from idx. They are held stable from ISSUE through COMMIT.
- States: IDLE, ISSUE, WAIT, COMMIT, FINISH.
- IDLE:
  - If iSTART=1 and iEPOCHS!=0: capture iEPOCHS, set idx=0, set oEPOCH_CNT=0, go to ISSUE.
  - If iSTART=1 and iEPOCHS=0: go to FINISH. No pattern is issued.
  - Otherwise stay in IDLE.
- ISSUE: exactly 1 cycle. oPAT_VALID=1. Load wait counter with LAT-1. Go to WAIT.
- WAIT:
  - Counter>0: decrement it.
  - Counter=0: go to COMMIT. WAIT therefore lasts exactly LAT cycles.
- COMMIT: exactly 1 cycle. oLOAD_W=1. Then:
  - If idx<3: idx+1, go to ISSUE.
  - If idx=3 and oEPOCH_CNT+1 < captured epochs: oEPOCH_CNT+1, idx=0, go to ISSUE.
  - If idx=3 and oEPOCH_CNT+1 = captured epochs: oEPOCH_CNT+1, go to FINISH.
- FINISH: 1 cycle. oDONE=1. Return to IDLE. oEPOCH_CNT holds its value in IDLE until the next accepted start.
- Timing: if start is accepted at edge k, then:
  - ISSUE occupies cycle k+1.
  - The n-th oLOAD_W (n=1..4E) occurs in cycle k+n*(LAT+2).
  - oDONE occurs in cycle k+4E*(LAT+2)+1.
- iABORT=1 in any non-IDLE state: next state IDLE. The abort cycle and following cycles produce no oLOAD_W and no oDONE. idx and oX0/oX1/oTEACH return to 0. oEPOCH_CNT holds. iABORT has priority over all other transitions.
- iSTART while oBUSY=1: ignored. iEPOCHS changes after capture: ignored.
- Epoch arithmetic: unsigned EPOCH_W bits. iEPOCHS = 2^EPOCH_W-1 is legal; the counter never wraps because the run stops at the captured count.
- Reset mid-run: immediate return to IDLE with all outputs 0. Any in-flight datapath result is discarded, because no commit occurs.

Test Plan:
- Reset check: assert iRST asynchronously mid-cycle during WAIT -> all outputs 0 immediately; state IDLE; no oLOAD_W afterwards.
- Single epoch, LAT=40: iEPOCHS=1, start at edge k -> oPAT_VALID at k+1/k+43/k+85/k+127; oLOAD_W at k+42/84/126/168; (oX0,oX1,oTEACH) sequence (0,0,0),(0,1,1),(1,0,1),(1,1,0); oDONE at k+169; oEPOCH_CNT=1.
- Multi-epoch, LAT=1: iEPOCHS=3 -> exactly 12 oLOAD_W pulses spaced 3 cycles apart; idx wraps 3->0 twice; final oEPOCH_CNT=3; oDONE at k+37.
- Zero epochs: iEPOCHS=0 with iSTART -> no oPAT_VALID, no oLOAD_W; oDONE one cycle after the start edge; oEPOCH_CNT=0.
- Abort: iABORT during the COMMIT cycle of pattern 2 -> oLOAD_W suppressed in that cycle; next cycle IDLE with oBUSY=0; no oDONE; oEPOCH_CNT unchanged.
- Start while busy: pulse iSTART with iEPOCHS=5 mid-run (run started with iEPOCHS=2) -> ignored; run finishes after 8 commits with oEPOCH_CNT=2.
